// File: rtl/cache_set_array_pkg.sv
// Shared types for the split L1 set array: trace commands, cache lines, FSM states.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package my_struct_package;

    localparam int TAG_W       = 12;
    localparam int IDX_FIELD_W = 14;
    localparam int OFF_W       = 6;
    localparam int LRU_W       = 3;

    localparam int DWAYS = 8;
    localparam int IWAYS = 4;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef struct packed {
        logic [TAG_W-1:0]       tag;
        logic [IDX_FIELD_W-1:0] index;
        logic [OFF_W-1:0]       offset;
    } address_t;

    typedef struct packed {
        logic [3:0] n;
        address_t   address;
    } command_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        mesi_t            MESI_bits;
        logic [LRU_W-1:0] lru;
    } cache_line_t;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2
    } state_t;

    localparam logic [3:0] CMD_RD_D    = 4'd0;
    localparam logic [3:0] CMD_WR_D    = 4'd1;
    localparam logic [3:0] CMD_RD_I    = 4'd2;
    localparam logic [3:0] CMD_SNP_INV = 4'd3;
    localparam logic [3:0] CMD_SNP_RD  = 4'd4;
    localparam logic [3:0] CMD_CLR     = 4'd8;
    localparam logic [3:0] CMD_PRN     = 4'd9;

    // Cleared line: invalid, tag zero, LRU seeded with the way number so
    // the replacement order is a valid permutation right after a clear.
    function automatic cache_line_t invalid_line(input int way);
        cache_line_t l;
        l.tag       = '0;
        l.MESI_bits = MESI_I;
        l.lru       = LRU_W'(way);
        return l;
    endfunction

endpackage

// File: rtl/cache_set_array_set_ram.sv
// Per-set storage of WAYS cache lines: synchronous write, registered read.
// Latency: read data valid the cycle after re; write lands at the clock edge.
// Backpressure: none; the caller guarantees it never reads and writes one set in the same cycle.
module set_ram
    import my_struct_package::*;
#(
    parameter int WAYS = 8,
    parameter int SETS = 16384,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  cache_line_t [WAYS-1:0] wdata,
    input  logic                   re,
    input  logic [IDX_W-1:0]       raddr,
    output cache_line_t [WAYS-1:0] rdata
);

    cache_line_t [WAYS-1:0] mem [SETS];

    // Array contents are not reset; the clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds the serviced set; zeroed on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cache_set_array.sv
// Split L1 set array: reads the addressed data/instruction set, writes back the processor's update.
// Latency: set presented 1 cycle after acceptance, written back at the end of that LOOKUP cycle.
// Backpressure: cmd_ready low in LOOKUP and throughout the SETS-cycle clear sweep.
module cache_set_array
    import my_struct_package::*;
#(
    parameter int SETS  = 16384,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  command_t                instruction,
    output command_t                instr_out,
    output cache_line_t [DWAYS-1:0] current_line_d,
    output cache_line_t [IWAYS-1:0] current_line_i,
    input  cache_line_t [DWAYS-1:0] return_line_d,
    input  cache_line_t [IWAYS-1:0] return_line_i,
    output logic                    busy,
    output logic                    clear_done,
    output logic [CNT_W-1:0]        access_count,
    output logic [CNT_W-1:0]        hit_count
);

    localparam int IDX_W = $clog2(SETS);

    state_t                  state;
    logic [IDX_W-1:0]        ptr;
    logic                    accept;
    logic                    cmd_is_access;
    logic [IDX_W-1:0]        cmd_idx;
    logic [IDX_W-1:0]        cur_idx;
    logic                    cur_is_i;
    logic                    hit;
    logic                    d_we;
    logic                    i_we;
    logic [IDX_W-1:0]        waddr;
    cache_line_t [DWAYS-1:0] d_wdata;
    cache_line_t [IWAYS-1:0] i_wdata;
    cache_line_t [DWAYS-1:0] inv_d;
    cache_line_t [IWAYS-1:0] inv_i;
    logic                    unused_addr_bits;

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign clear_done    = (state == CLEAR) && (ptr == IDX_W'(SETS - 1));
    assign accept        = cmd_valid && cmd_ready;
    assign cmd_is_access = (instruction.n <= CMD_SNP_RD);
    // Index is taken modulo SETS: only the low bits address the array.
    assign cmd_idx       = instruction.address.index[IDX_W-1:0];
    assign cur_idx       = instr_out.address.index[IDX_W-1:0];
    assign cur_is_i      = (instr_out.n == CMD_RD_I);

    assign unused_addr_bits = ^{instruction.address.offset, instruction.address.index,
                                instr_out.address.offset, instr_out.address.index};

    // Constant cleared sets written during the sweep.
    always_comb begin
        inv_d = '0;
        inv_i = '0;
        for (int w = 0; w < DWAYS; w++) inv_d[w] = invalid_line(w);
        for (int w = 0; w < IWAYS; w++) inv_i[w] = invalid_line(w);
    end

    // Hit check on the set registered at acceptance, held stable through LOOKUP.
    always_comb begin
        hit = 1'b0;
        if (cur_is_i) begin
            for (int w = 0; w < IWAYS; w++) begin
                if (current_line_i[w].tag == instr_out.address.tag &&
                    current_line_i[w].MESI_bits != MESI_I) hit = 1'b1;
            end
        end else begin
            for (int w = 0; w < DWAYS; w++) begin
                if (current_line_d[w].tag == instr_out.address.tag &&
                    current_line_d[w].MESI_bits != MESI_I) hit = 1'b1;
            end
        end
    end

    // Write port steering: sweep writes both arrays, LOOKUP writes only the serviced cache.
    always_comb begin
        d_we    = 1'b0;
        i_we    = 1'b0;
        waddr   = cur_idx;
        d_wdata = return_line_d;
        i_wdata = return_line_i;
        case (state)
            CLEAR: begin
                d_we    = 1'b1;
                i_we    = 1'b1;
                waddr   = ptr;
                d_wdata = inv_d;
                i_wdata = inv_i;
            end
            LOOKUP: begin
                d_we = !cur_is_i;
                i_we = cur_is_i;
            end
            default: ;
        endcase
    end

    set_ram #(.WAYS(DWAYS), .SETS(SETS)) u_data_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (d_we),
        .waddr (waddr),
        .wdata (d_wdata),
        .re    (accept && cmd_is_access),
        .raddr (cmd_idx),
        .rdata (current_line_d)
    );

    set_ram #(.WAYS(IWAYS), .SETS(SETS)) u_inst_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (i_we),
        .waddr (waddr),
        .wdata (i_wdata),
        .re    (accept && cmd_is_access),
        .raddr (cmd_idx),
        .rdata (current_line_i)
    );

    // Control FSM: clear sweep, command dispatch, and saturating statistics.
    // Counters update at the close of LOOKUP, when the hit result is known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            ptr          <= '0;
            instr_out    <= '0;
            access_count <= '0;
            hit_count    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == IDX_W'(SETS - 1)) begin
                        ptr   <= '0;
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (cmd_is_access) begin
                            instr_out <= instruction;
                            state     <= LOOKUP;
                        end else if (instruction.n == CMD_CLR) begin
                            state <= CLEAR;
                        end
                    end
                end
                LOOKUP: begin
                    state <= IDLE;
                    if (access_count != '1) access_count <= access_count + CNT_W'(1);
                    if (hit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_set_array.sv
module tb_cache_set_array;
    import my_struct_package::*;

    localparam int SETS = 4;

    typedef cache_line_t [DWAYS-1:0] dset_t;
    typedef cache_line_t [IWAYS-1:0] iset_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    command_t    instruction = '0;
    dset_t       return_line_d = '0;
    iset_t       return_line_i = '0;

    logic        cmd_ready, busy, clear_done;
    command_t    instr_out;
    dset_t       current_line_d;
    iset_t       current_line_i;
    logic [7:0]  access_count, hit_count;

    logic        s_cmd_ready, s_busy, s_clear_done;
    command_t    s_instr_out;
    dset_t       s_current_line_d;
    iset_t       s_current_line_i;
    logic [1:0]  s_access_count, s_hit_count;

    int total = 0;
    int bad   = 0;

    // reference model: plain arrays of sets and unbounded counts
    dset_t md [SETS];
    iset_t mi [SETS];
    int    n_acc = 0;
    int    n_hit = 0;

    always #5 clk = ~clk;

    cache_set_array #(.SETS(SETS), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .instruction(instruction), .instr_out(instr_out),
        .current_line_d(current_line_d), .current_line_i(current_line_i),
        .return_line_d(return_line_d), .return_line_i(return_line_i),
        .busy(busy), .clear_done(clear_done),
        .access_count(access_count), .hit_count(hit_count)
    );

    cache_set_array #(.SETS(SETS), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .instruction(instruction), .instr_out(s_instr_out),
        .current_line_d(s_current_line_d), .current_line_i(s_current_line_i),
        .return_line_d(return_line_d), .return_line_i(return_line_i),
        .busy(s_busy), .clear_done(s_clear_done),
        .access_count(s_access_count), .hit_count(s_hit_count)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < DWAYS; w++) md[s][w] = '{tag: '0, MESI_bits: MESI_I, lru: 3'(w)};
            for (int w = 0; w < IWAYS; w++) mi[s][w] = '{tag: '0, MESI_bits: MESI_I, lru: 3'(w)};
        end
    endfunction

    function automatic logic [TAG_W-1:0] pick_tag();
        logic [TAG_W-1:0] pool [4];
        pool = '{12'h123, 12'h000, 12'hABC, 12'h5A5};
        return pool[$urandom_range(0, 3)];
    endfunction

    function automatic cache_line_t rnd_line();
        cache_line_t l;
        l.tag       = pick_tag();
        l.MESI_bits = mesi_t'($urandom_range(0, 3));
        l.lru       = 3'($urandom_range(0, 7));
        return l;
    endfunction

    function automatic dset_t rnd_d();
        dset_t r;
        for (int w = 0; w < DWAYS; w++) r[w] = rnd_line();
        return r;
    endfunction

    function automatic iset_t rnd_i();
        iset_t r;
        for (int w = 0; w < IWAYS; w++) r[w] = rnd_line();
        return r;
    endfunction

    // high index bits are random so that modulo-SETS indexing is exercised
    function automatic command_t mk(input logic [3:0] n, input logic [TAG_W-1:0] tag, input int idx);
        command_t c;
        c.n              = n;
        c.address.tag    = tag;
        c.address.index  = 14'(idx + SETS * $urandom_range(0, 1000));
        c.address.offset = 6'($urandom_range(0, 63));
        return c;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_acc"},   access_count,   sat(n_acc, 8));
        chk({tag, "_hit"},   hit_count,      sat(n_hit, 8));
        chk({tag, "_sacc"},  s_access_count, sat(n_acc, 2));
        chk({tag, "_shit"},  s_hit_count,    sat(n_hit, 2));
    endtask

    // expects to be called in the first cycle of a sweep
    task automatic check_sweep(input string tag);
        for (int k = 0; k < SETS; k++) begin
            chk({tag, "_sweep_rdy"},  cmd_ready,  1'b0);
            chk({tag, "_sweep_done"}, clear_done, (k == SETS - 1));
            step();
        end
        chk({tag, "_after_rdy"},  cmd_ready,  1'b1);
        chk({tag, "_after_done"}, clear_done, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rdy",   cmd_ready,      1'b0);
        chk("rst_busy",  busy,           1'b1);
        chk("rst_done",  clear_done,     1'b0);
        chk("rst_instr", instr_out,      '0);
        chk("rst_curd",  current_line_d, '0);
        chk("rst_curi",  current_line_i, '0);
        chk("rst_acc",   access_count,   '0);
        chk("rst_hit",   hit_count,      '0);
        step();
        #5;
        rst_n = 1'b1;
        n_acc = 0;
        n_hit = 0;
        model_clear();
        check_sweep("rst");
    endtask

    task automatic issue(input command_t c, input dset_t rd, input iset_t ri, input logic mid_reset);
        int   s;
        int   waitc;
        logic hit;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            step();
            waitc++;
        end
        if (!cmd_ready) chk("ready_timeout", cmd_ready, 1'b1);
        instruction = c;
        cmd_valid   = 1'b1;
        step();
        cmd_valid = 1'b0;
        s = int'(c.address.index) % SETS;
        if (c.n <= 4'd4) begin
            hit = 1'b0;
            if (c.n == CMD_RD_I) begin
                for (int w = 0; w < IWAYS; w++)
                    if (mi[s][w].tag == c.address.tag && mi[s][w].MESI_bits != MESI_I) hit = 1'b1;
            end else begin
                for (int w = 0; w < DWAYS; w++)
                    if (md[s][w].tag == c.address.tag && md[s][w].MESI_bits != MESI_I) hit = 1'b1;
            end
            chk("lk_rdy",   cmd_ready,      1'b0);
            chk("lk_busy",  busy,           1'b1);
            chk("lk_instr", instr_out,      c);
            chk("lk_curd",  current_line_d, md[s]);
            chk("lk_curi",  current_line_i, mi[s]);
            return_line_d = rd;
            return_line_i = ri;
            if (mid_reset) begin
                do_reset();
                return;
            end
            step();
            if (c.n == CMD_RD_I) mi[s] = ri;
            else                 md[s] = rd;
            n_acc++;
            if (hit) n_hit++;
            chk("acc_rdy", cmd_ready, 1'b1);
            chk_counts("acc");
            return_line_d = rnd_d();
            return_line_i = rnd_i();
        end else if (c.n == CMD_CLR) begin
            model_clear();
            check_sweep("clr");
            chk_counts("clr");
        end else begin
            chk("other_rdy",  cmd_ready, 1'b1);
            chk("other_busy", busy,      1'b0);
            chk_counts("other");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        dset_t    rd;
        iset_t    ri;
        command_t c;
        int       r;

        step();
        do_reset();

        // cleared set 2: all invalid, LRU 0..7
        issue(mk(CMD_RD_D, 12'h123, 2), rnd_d(), rnd_i(), 1'b0);

        // fill way 7 of data set 1, then hit on it
        c = mk(CMD_RD_D, 12'h123, 1);
        rd = md[1];
        rd[7] = '{tag: 12'h123, MESI_bits: MESI_E, lru: 3'd7};
        issue(c, rd, rnd_i(), 1'b0);
        issue(mk(CMD_RD_D, 12'h123, 1), md[1], rnd_i(), 1'b0);
        chk("fill_hit", hit_count, 8'd1);

        // instruction fill of set 3 leaves data set 3 alone
        ri = mi[3];
        ri[0] = '{tag: 12'h0AA, MESI_bits: MESI_S, lru: 3'd0};
        issue(mk(CMD_RD_I, 12'h0AA, 3), rnd_d(), ri, 1'b0);
        issue(mk(CMD_RD_D, 12'h0AA, 3), md[3], rnd_i(), 1'b0);
        issue(mk(CMD_RD_I, 12'h0AA, 3), rnd_d(), mi[3], 1'b0);

        // clear, then the filled address misses; print code is a no-op
        issue(mk(CMD_CLR, 12'h000, 0), rnd_d(), rnd_i(), 1'b0);
        issue(mk(CMD_RD_D, 12'h123, 1), md[1], rnd_i(), 1'b0);
        issue(mk(CMD_PRN, 12'h123, 1), rnd_d(), rnd_i(), 1'b0);

        // reset during LOOKUP drops the write-back
        issue(mk(CMD_WR_D, 12'h123, 1), rd, rnd_i(), 1'b1);
        issue(mk(CMD_RD_D, 12'h123, 1), md[1], rnd_i(), 1'b0);

        // reset two sets into a sweep restarts it from set 0
        instruction = mk(CMD_CLR, 12'h000, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("midclr_busy", busy, 1'b1);
        do_reset();

        // five hits saturate the 2-bit hit counter at 3
        issue(mk(CMD_RD_D, 12'h123, 1), rd, rnd_i(), 1'b0);
        for (int k = 0; k < 5; k++) issue(mk(CMD_SNP_RD, 12'h123, 1), md[1], rnd_i(), 1'b0);
        chk("sat_hit", s_hit_count, 2'd3);
        chk("sat_hit_wide", hit_count, 8'd5);

        // random traffic
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 19);
            if (r < 15)       c = mk(4'(r % 5), pick_tag(), $urandom_range(0, SETS - 1));
            else if (r == 15) c = mk(CMD_CLR, pick_tag(), 0);
            else if (r < 18)  c = mk(CMD_PRN, pick_tag(), $urandom_range(0, SETS - 1));
            else if (r == 18) c = mk(4'($urandom_range(5, 7)), pick_tag(), 0);
            else              c = mk(4'($urandom_range(10, 15)), pick_tag(), 0);
            issue(c, rnd_d(), rnd_i(), ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_set_array.md
Name: cache_set_array

Overview:
- Set storage for the split L1 model: 8-way data cache and 4-way instruction cache, indexed by `instruction.address.index`.
- Accepts trace commands from the trace reader and reads the addressed set. For one cycle it presents that set to the processor stage as `current_line_d`/`current_line_i`.
- At the end of that cycle it writes back the `return_line_d`/`return_line_i` the processor stage computes.
- Also owns the clear sweep (reset and command 8) and the access/hit statistics counters.

Parameters:
- `SETS`, 16384, number of sets; power of two; index width = `$clog2(SETS)`.
- `CNT_W`, 32, width of the statistics counters.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  upstream has a command on `instruction`
- `cmd_ready`  out  1  block can accept a command this cycle
- `instruction`  in  `command_t`  trace command: n, address (tag/index/offset)
- `instr_out`  out  `command_t`  latched command driven to the processor stage
- `current_line_d`  out  `cache_line_t[8]`  data-cache set being serviced
- `current_line_i`  out  `cache_line_t[4]`  instruction-cache set being serviced
- `return_line_d`  in  `cache_line_t[8]`  updated data set from the processor stage
- `return_line_i`  in  `cache_line_t[4]`  updated instruction set from the processor stage
- `busy`  out  1  high in any state other than IDLE
- `clear_done`  out  1  one-cycle pulse when a clear sweep finishes
- `access_count`  out  `CNT_W`  accepted cache-access commands (n = 0,1,2,3,4)
- `hit_count`  out  `CNT_W`  accepted accesses that hit

Behaviour:
- **Reset (async, `rst_n` = 0):**
  - State = CLEAR, sweep pointer = 0.
  - `cmd_ready` = 0, `busy` = 1, `clear_done` = 0, both counters = 0.
  - `instr_out` = 0; `current_line_*` = all-zero lines.
- **Invalid line value** (written by every clear): tag = 0, `MESI_bits` = I, LRU = way number (0..7 data, 0..3 instruction), so LRU values are distinct after a clear.
- **States:**
  - CLEAR: writes the invalid line into every way of set[ptr], one set per cycle; ptr increments. After set `SETS-1` is written: `clear_done` pulses for 1 cycle, ptr → 0, next state = IDLE. A clear takes exactly `SETS` cycles.
  - IDLE: `cmd_ready` = 1. A command is accepted when `cmd_valid` & `cmd_ready` at the rising edge. On acceptance, dispatch by n:
    - n = 0,1,3,4 (data) or n = 2 (instruction): latch `instruction` into `instr_out`; register both ways-arrays of set[index] into `current_line_d`/`current_line_i`; next = LOOKUP.
    - n = 8: next = CLEAR; counters unchanged.
    - n = 9 or any other code: consumed, no state change, no array or counter effect.
  - LOOKUP: exactly 1 cycle; outputs stable throughout. At the closing edge:
    - data command: write `return_line_d` into data set[index]; instruction set untouched.
    - n = 2: write `return_line_i` into instruction set[index]; data set untouched.
    - next = IDLE.
- **Throughput:** 1 access per 2 cycles. `cmd_ready` is 0 in LOOKUP and CLEAR; the upstream holds `instruction` until accepted.
- **Hit** = any way of the addressed cache (data for n ≠ 2, instruction for n = 2) with tag match and `MESI_bits` ≠ I, evaluated on the stored set at acceptance.
  - `access_count`++ on each accepted n ∈ {0..4}.
  - `hit_count`++ additionally when it hits.
  - Both counters saturate at all-ones; they never wrap.
- **Back-to-back same set:** the second access reads the value written at the end of the first LOOKUP. No bypass is needed, since acceptance occurs only in IDLE after the write.
- **Reset mid-LOOKUP:** the pending write-back is dropped.
- **Reset mid-CLEAR:** the sweep restarts at set 0.
- **Address widths:** `instruction.address.index` is used modulo `SETS`; the tag is stored unmodified.
- `return_line_*` inputs are ignored outside LOOKUP.

Decomposition:
- In `my_struct_package`:
  - `state_t` enum {CLEAR, IDLE, LOOKUP}
  - command codes as named constants (`CMD_RD_D`=0, `CMD_WR_D`=1, `CMD_RD_I`=2, `CMD_SNP_*`=3/4, `CMD_CLR`=8, `CMD_PRN`=9)
  - `DWAYS`=8, `IWAYS`=4
  - function `invalid_line(way)`
- `command_t`, `cache_line_t` and the MESI enum are reused unchanged.
- One sub-module, `set_ram`, parameterised by ways. It is a synchronous-write, registered-read array of `cache_line_t[WAYS]`, instantiated twice (data, instruction).

Test Plan (SETS=4 unless stated):
- Reset release → `cmd_ready` low for 4 cycles, `clear_done` pulse on the 4th, then `cmd_ready` = 1; reading set 2 shows all ways MESI = I, LRU = 0..7.
- n=0, addr tag 0x123 idx 1 → LOOKUP 1 cycle later shows invalid set; processor returns way7 tag 0x123 MESI = E. Repeat n=0 same address → `hit_count` = 1, `access_count` = 2.
- n=2 idx 3 with returned instruction line → data set 3 unchanged; instruction set 3 holds the new line; `cmd_ready` pattern 1,0,1.
- After filling sets, issue n=8 → 4-cycle sweep, `clear_done` pulse, same address now misses; counters unchanged by n=8; n=9 consumed in 1 cycle with no effect.
- Assert `rst_n` = 0 during LOOKUP and again at sweep pointer 2 → write-back dropped, sweep restarts from set 0, counters = 0.
- `CNT_W`=2: five hits → `hit_count` saturates at 3.
